// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the MPU command engine.
//   - opcode and status-code constants
//   - FSM state encoding
//   - flag bundle returned by the ALU core
//   - opcode validity helper
// Optional feature macro: MPU_CHECKSUM_EN (adds GET_CK state and ST_CKSUM).
package mpu_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;
  localparam logic [7:0] OP_CMP = 8'h08;

  localparam logic [7:0] ST_BAD_OP  = 8'hE1;
  localparam logic [7:0] ST_RX_ERR  = 8'hE2;
  localparam logic [7:0] ST_TIMEOUT = 8'hE3;
`ifdef MPU_CHECKSUM_EN
  localparam logic [7:0] ST_CKSUM   = 8'hE4;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
`ifdef MPU_CHECKSUM_EN
    GET_CK,
`endif
    EXEC,
    SEND,
    WAIT
  } state_t;

  // Packed so that {4'h0, flags} is directly the status byte {V,N,Z,C}.
  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } mpu_flags_t;

  function automatic logic op_valid(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/mpu_alu_core.sv
// mpu_alu_core: combinational ALU for the MPU command engine.
// Parameters: DATA_W - operand/result width (multiple of 8, 8..64).
// Ports:
//   op     in  8      opcode (mpu_pkg OP_*)
//   a, b   in  DATA_W operands
//   result out DATA_W operation result (0 for CMP and unknown opcodes)
//   flags  out 4      {V,N,Z,C}
module mpu_alu_core
  import mpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output mpu_flags_t        flags
);

  localparam int unsigned M    = DATA_W - 1;
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   amt;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   shl;
  logic [DATA_W:0]   shr;

  assign amt = b[SH_W-1:0];

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    // Extra guard bit on the exit side catches the last bit shifted out;
    // it stays 0 for a zero shift amount.
    shl    = {1'b0, a} << amt;
    shr    = {a, 1'b0} >> amt;
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result  = sum[M:0];
        flags.c = sum[DATA_W];
        flags.v = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB, OP_CMP: begin
        result  = (op == OP_SUB) ? diff[M:0] : '0;
        flags.c = diff[DATA_W];
        flags.v = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result  = shl[M:0];
        flags.c = shl[DATA_W];
      end
      OP_SHR: begin
        result  = shr[DATA_W:1];
        flags.c = shr[0];
      end
      default: ;
    endcase
    if (op == OP_CMP) begin
      flags.z = (diff[M:0] == '0);
      flags.n = diff[M];
    end else begin
      flags.z = (result == '0);
      flags.n = result[M];
    end
  end

endmodule

// File: rtl/mpu_cmd_engine.sv
// mpu_cmd_engine: byte-serial command engine between UART Rx and UART Tx.
// Receives opcode, operand A, operand B (DATA_W/8 bytes each, MSB first),
// executes one ALU operation and returns a status byte plus result bytes
// through a tx_en / tx_complete handshake. Error responses are one byte.
// Parameters:
//   DATA_W      operand/result width (multiple of 8, 8..64)
//   TIMEOUT_CYC max cycles between frame bytes, 0 disables the timeout
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rx_data        received byte, valid with rx_complete
//   rx_complete    strobe: new byte on rx_data
//   rx_error       strobe: Rx framing error
//   tx_data        byte to transmit, held until tx_complete
//   tx_en          one-cycle request to transmit tx_data
//   tx_complete    strobe: Tx finished the current byte
//   busy           high in every state except IDLE
// Optional feature macro: MPU_CHECKSUM_EN (XOR checksum byte on both the
// command frame and the success response).
module mpu_cmd_engine
  import mpu_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_complete,
  input  logic       rx_error,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_complete,
  output logic       busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
`ifdef MPU_CHECKSUM_EN
  localparam int unsigned RESP_BYTES = NB + 2;
`else
  localparam int unsigned RESP_BYTES = NB + 1;
`endif
  localparam int unsigned RESP_W    = 8 * RESP_BYTES;
  localparam int unsigned RCNT_W    = $clog2(RESP_BYTES + 1);
  localparam int unsigned TMO_LIMIT = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 1;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

  state_t              state_q, state_d;
  logic [7:0]          opcode_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [RESP_W-1:0]   resp_q;
  logic [RCNT_W-1:0]   resp_cnt_q;
`ifdef MPU_CHECKSUM_EN
  logic [7:0]          ck_q;
  logic [7:0]          ck_out;
`endif

  logic [DATA_W-1:0]   alu_result;
  mpu_flags_t          alu_flags;
  logic [7:0]          status;
  logic [RESP_W-1:0]   resp_ok;

  logic                in_get;
  logic                last_byte;
  logic                tmo_hit;
  logic                byte_acc;
  logic                err_load;
  logic [7:0]          err_code;

  mpu_alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

`ifdef MPU_CHECKSUM_EN
  assign in_get = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_CK);
`else
  assign in_get = (state_q == GET_A) || (state_q == GET_B);
`endif
  assign last_byte = (byte_cnt_q == CNT_W'(NB - 1));
  // tmo_q counts cycles since the last accepted byte starting at 1; the abort
  // is taken one cycle early so the E3 tx_en lands TIMEOUT_CYC cycles after it.
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_q >= TMO_W'(TMO_LIMIT));

  assign tx_data = resp_q[RESP_W-1 -: 8];
  assign tx_en   = (state_q == SEND);
  assign busy    = (state_q != IDLE);

  always_comb begin
    status = {4'h0, alu_flags};
`ifdef MPU_CHECKSUM_EN
    ck_out = status;
    for (int unsigned i = 0; i < NB; i++) ck_out = ck_out ^ alu_result[8*i +: 8];
    resp_ok = {status, alu_result, ck_out};
`else
    resp_ok = {status, alu_result};
`endif
  end

  always_comb begin
    state_d  = state_q;
    byte_acc = 1'b0;
    err_load = 1'b0;
    err_code = '0;
    if (in_get && rx_error) begin
      state_d  = SEND;
      err_load = 1'b1;
      err_code = ST_RX_ERR;
    end else if (in_get && !rx_complete && tmo_hit) begin
      state_d  = SEND;
      err_load = 1'b1;
      err_code = ST_TIMEOUT;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_complete) begin
            if (op_valid(rx_data)) begin
              state_d = GET_A;
            end else begin
              state_d  = SEND;
              err_load = 1'b1;
              err_code = ST_BAD_OP;
            end
          end
        end
        GET_A: begin
          if (rx_complete) begin
            byte_acc = 1'b1;
            if (last_byte) state_d = GET_B;
          end
        end
        GET_B: begin
          if (rx_complete) begin
            byte_acc = 1'b1;
`ifdef MPU_CHECKSUM_EN
            if (last_byte) state_d = GET_CK;
`else
            if (last_byte) state_d = EXEC;
`endif
          end
        end
`ifdef MPU_CHECKSUM_EN
        GET_CK: begin
          if (rx_complete) begin
            byte_acc = 1'b1;
            if (rx_data == ck_q) begin
              state_d = EXEC;
            end else begin
              state_d  = SEND;
              err_load = 1'b1;
              err_code = ST_CKSUM;
            end
          end
        end
`endif
        EXEC: state_d = SEND;
        SEND: state_d = WAIT;
        WAIT: begin
          if (tx_complete) state_d = (resp_cnt_q == RCNT_W'(1)) ? IDLE : SEND;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
`ifdef MPU_CHECKSUM_EN
      ck_q       <= '0;
`endif
    end else begin
      if ((state_q == IDLE) && rx_complete) begin
        opcode_q   <= rx_data;
        op_a_q     <= '0;
        op_b_q     <= '0;
        byte_cnt_q <= '0;
        tmo_q      <= TMO_W'(1);
`ifdef MPU_CHECKSUM_EN
        ck_q       <= rx_data;
`endif
      end

      if (byte_acc) begin
        tmo_q      <= TMO_W'(1);
        byte_cnt_q <= last_byte ? '0 : byte_cnt_q + CNT_W'(1);
        if (state_q == GET_A) op_a_q <= (op_a_q << 8) | DATA_W'(rx_data);
        if (state_q == GET_B) op_b_q <= (op_b_q << 8) | DATA_W'(rx_data);
`ifdef MPU_CHECKSUM_EN
        ck_q       <= ck_q ^ rx_data;
`endif
      end else if (in_get && (TIMEOUT_CYC != 0)) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (err_load) begin
        resp_q     <= {err_code, (RESP_W-8)'(0)};
        resp_cnt_q <= RCNT_W'(1);
      end else if (state_q == EXEC) begin
        resp_q     <= resp_ok;
        resp_cnt_q <= RCNT_W'(RESP_BYTES);
      end else if ((state_q == WAIT) && tx_complete) begin
        resp_q     <= resp_q << 8;
        resp_cnt_q <= resp_cnt_q - RCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mpu_cmd_engine.sv
module tb_mpu_cmd_engine;

  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic       rx_error;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_complete;
  logic       busy;

  mpu_cmd_engine #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_complete (rx_complete),
    .rx_error    (rx_error),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_complete (tx_complete),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         cyc         = 0;
  int         last_rx_cyc = 0;
  int         lat_exp     = -1;
  int         rst_epoch   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_resp(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back(s);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
`ifdef MPU_CHECKSUM_EN
    exp_q.push_back(s ^ hi ^ lo);
`endif
  endtask

  // Reference: integer arithmetic on 16-bit values, signed range test for V.
  task automatic push_model(input int unsigned op, input int unsigned a, input int unsigned b);
    int unsigned res, diff, amt, st;
    int          sa, sb, sr;
    bit          c, v, z, n;
    sa   = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb   = (b >= 32768) ? int'(b) - 65536 : int'(b);
    diff = (a + 65536 - b) % 65536;
    amt  = b % 16;
    res  = 0; c = 0; v = 0;
    case (op)
      1: begin
        res = (a + b) % 65536; c = (a + b) > 65535;
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      2, 8: begin
        res = diff; c = (a < b);
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
      end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: begin
        res = (a << amt) % 65536;
        c = (amt != 0) && (((a >> (16 - amt)) & 1) == 1);
      end
      7: begin
        res = a >> amt;
        c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1);
      end
      default: ;
    endcase
    z = (res == 0);
    n = (res >= 32768);
    if (op == 8) res = 0;
    st = (v ? 8 : 0) + (n ? 4 : 0) + (z ? 2 : 0) + (c ? 1 : 0);
    push_resp(st[7:0], res[15:8], res[7:0]);
  endtask

  task automatic send_strobe(input logic [7:0] b, input logic cmpl, input logic err);
    @(posedge clk); #1;
    rx_data = b; rx_complete = cmpl; rx_error = err;
    @(posedge clk); #1;
    rx_complete = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    send_strobe(op, 1'b1, 1'b0);
    send_strobe(a[15:8], 1'b1, 1'b0);
    send_strobe(a[7:0], 1'b1, 1'b0);
    send_strobe(b[15:8], 1'b1, 1'b0);
    send_strobe(b[7:0], 1'b1, 1'b0);
`ifdef MPU_CHECKSUM_EN
    send_strobe(op ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0], 1'b1, 1'b0);
`endif
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_q_below(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() < n) ok = 1'b1;
    end
    check("first_byte_seen", 32'(ok), 32'd1);
  endtask

  int unsigned tv_op[13] = '{2, 1, 3, 4, 5, 6, 6, 7, 7, 7, 8, 8, 2};
  int unsigned tv_a [13] = '{'h8000, 'h7FFF, 'hF0F0, 'hF000, 'h1234, 'h0003, 'h1234,
                             'h8001, 'h8001, 'hFFFF, 'h0007, 'h8000, 'h0005};
  int unsigned tv_b [13] = '{'h0001, 'h0001, 'h0FF0, 'h000F, 'h1234, 'h000F, 'h0010,
                             'h0001, 'h0011, 'h000F, 'h0005, 'h0001, 'h0003};

  initial begin
    bit seen;
    rst_n = 1'b0; rx_data = '0; rx_complete = 1'b0; rx_error = 1'b0; tx_complete = 1'b0;

    fork
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      begin : monitor
        logic prev_en;
        prev_en = 1'b0;
        forever begin
          @(negedge clk);
          cyc++;
          if (rx_complete) last_rx_cyc = cyc;
          if (rst_n && tx_en) begin
            if (prev_en) check("tx_en_single_cycle", 32'(prev_en), 32'd0);
            if (exp_q.size() == 0) check("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
            else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            if (lat_exp >= 0) begin
              check("first_tx_latency", 32'(cyc - last_rx_cyc), 32'(lat_exp));
              lat_exp = -1;
            end
          end
          prev_en = tx_en;
        end
      end
      begin : tx_model
        logic [7:0] held;
        int         ep;
        forever begin
          @(negedge clk);
          if (rst_n && tx_en) begin
            held = tx_data;
            ep   = rst_epoch;
            repeat (20) @(posedge clk);
            #1 tx_complete = 1'b1;
            @(negedge clk);
            if (ep == rst_epoch) check("tx_data_held", 32'(tx_data), 32'(held));
            @(posedge clk);
            #1 tx_complete = 1'b0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_tx_en", 32'(tx_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // hand-computed responses
    push_resp(8'h00, 8'h12, 8'h35); lat_exp = 2; send_frame(8'h01, 16'h1234, 16'h0001); wait_done("add");
    push_resp(8'h03, 8'h00, 8'h00); lat_exp = 2; send_frame(8'h01, 16'hFFFF, 16'h0001); wait_done("add_zc");
    push_resp(8'h05, 8'hFF, 8'hFF); send_frame(8'h02, 16'h0000, 16'h0001); wait_done("sub_nc");
    push_resp(8'h01, 8'h00, 8'h02); send_frame(8'h06, 16'h8001, 16'h0001); wait_done("shl_c");
    push_resp(8'h02, 8'h00, 8'h00); send_frame(8'h08, 16'h0005, 16'h0005); wait_done("cmp_eq");

    // model-driven opcode sweep
    for (int i = 0; i < 13; i++) begin
      push_model(tv_op[i], tv_a[i], tv_b[i]);
      lat_exp = 2;
      send_frame(8'(tv_op[i]), 16'(tv_a[i]), 16'(tv_b[i]));
      wait_done("model_frame");
    end

    // invalid opcodes, just outside the valid range on both sides
    exp_q.push_back(8'hE1); send_strobe(8'h7F, 1'b1, 1'b0); wait_done("bad_op_7f");
    exp_q.push_back(8'hE1); send_strobe(8'h00, 1'b1, 1'b0); wait_done("bad_op_00");
    exp_q.push_back(8'hE1); send_strobe(8'h09, 1'b1, 1'b0); wait_done("bad_op_09");

    // rx_error after two operand bytes
    exp_q.push_back(8'hE2);
    send_strobe(8'h01, 1'b1, 1'b0); send_strobe(8'h12, 1'b1, 1'b0); send_strobe(8'h34, 1'b1, 1'b0);
    send_strobe(8'h00, 1'b0, 1'b1);
    wait_done("rx_err");

    // rx_error and rx_complete together: error wins
    exp_q.push_back(8'hE2);
    send_strobe(8'h01, 1'b1, 1'b0); send_strobe(8'h12, 1'b1, 1'b1);
    wait_done("err_beats_byte");

    // rx_error in IDLE is ignored
    send_strobe(8'h00, 1'b0, 1'b1);
    push_model(4, 'h00F0, 'h0F00); send_frame(8'h04, 16'h00F0, 16'h0F00); wait_done("idle_err_ignored");

    // timeout after 01 12, then busy drops after the final tx_complete
    exp_q.push_back(8'hE3); lat_exp = TMO;
    send_strobe(8'h01, 1'b1, 1'b0); send_strobe(8'h12, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx_complete) seen = 1'b1;
    end
    check("timeout_tx_complete_seen", 32'(seen), 32'd1);
    check("busy_before_last_complete", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_last_complete", 32'(busy), 32'd0);
    check("timeout_resp_consumed", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    // byte arriving on the timeout cycle wins
    push_model(1, 'h1234, 'h0001); lat_exp = 2;
    send_strobe(8'h01, 1'b1, 1'b0); send_strobe(8'h12, 1'b1, 1'b0);
    repeat (97) @(posedge clk);
    send_strobe(8'h34, 1'b1, 1'b0); send_strobe(8'h00, 1'b1, 1'b0); send_strobe(8'h01, 1'b1, 1'b0);
`ifdef MPU_CHECKSUM_EN
    send_strobe(8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h00 ^ 8'h01, 1'b1, 1'b0);
`endif
    wait_done("byte_beats_timeout");

    // rx byte during the response is dropped
    push_model(5, 'h00FF, 'h0F0F); send_frame(8'h05, 16'h00FF, 16'h0F0F);
    wait_q_below(3);
    send_strobe(8'h7F, 1'b1, 1'b0);
    wait_done("rx_dropped_in_resp");

    // reset during WAIT aborts the response
    push_resp(8'h00, 8'h12, 8'h35); send_frame(8'h01, 16'h1234, 16'h0001);
    wait_q_below(3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    rst_epoch++;
    @(negedge clk);
    check("midreset_tx_data", 32'(tx_data), 32'h00);
    check("midreset_tx_en", 32'(tx_en), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);
    push_model(2, 'h1234, 'h0234); lat_exp = 2; send_frame(8'h02, 16'h1234, 16'h0234); wait_done("after_reset");

`ifdef MPU_CHECKSUM_EN
    exp_q.push_back(8'hE4);
    send_strobe(8'h01, 1'b1, 1'b0); send_strobe(8'h12, 1'b1, 1'b0); send_strobe(8'h34, 1'b1, 1'b0);
    send_strobe(8'h00, 1'b1, 1'b0); send_strobe(8'h01, 1'b1, 1'b0);
    send_strobe(8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h00 ^ 8'h01 ^ 8'hFF, 1'b1, 1'b0);
    wait_done("bad_checksum");
`endif

    repeat (5) @(negedge clk);
    check("expected_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
